// File: rtl/disco_dma.sv
// Block-transfer controller moving consecutive words between the disk and main memory.
// Disk-to-memory runs one word per cycle; memory-to-disk alternates a read and a write cycle.
module disco_dma #(
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned DISK_ADDR_WIDTH = 15,
  parameter int unsigned MEM_ADDR_WIDTH  = 10,
  parameter int unsigned LEN_WIDTH       = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       dir,
  input  logic [DISK_ADDR_WIDTH-1:0] disk_base,
  input  logic [MEM_ADDR_WIDTH-1:0]  mem_base,
  input  logic [LEN_WIDTH-1:0]       length,
  output logic                       busy,
  output logic                       done,
  output logic [DISK_ADDR_WIDTH-1:0] disk_addr,
  output logic [DATA_WIDTH-1:0]      disk_data,
  output logic                       disk_tr,
  input  logic [DATA_WIDTH-1:0]      disk_q,
  output logic [MEM_ADDR_WIDTH-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0]      mem_data,
  output logic                       mem_we,
  input  logic [DATA_WIDTH-1:0]      mem_q
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    D2M    = 3'd1,
    M2D_RD = 3'd2,
    M2D_WR = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t                     state, state_nx;
  logic [DISK_ADDR_WIDTH-1:0] disk_ptr, disk_ptr_nx;
  logic [MEM_ADDR_WIDTH-1:0]  mem_ptr, mem_ptr_nx;
  logic [LEN_WIDTH-1:0]       remaining, remaining_nx;

  // State and working registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      disk_ptr  <= '0;
      mem_ptr   <= '0;
      remaining <= '0;
    end else begin
      state     <= state_nx;
      disk_ptr  <= disk_ptr_nx;
      mem_ptr   <= mem_ptr_nx;
      remaining <= remaining_nx;
    end
  end

  // Next-state and Moore strobe decode; the transfer direction lives in the state encoding
  always_comb begin
    state_nx     = state;
    disk_ptr_nx  = disk_ptr;
    mem_ptr_nx   = mem_ptr;
    remaining_nx = remaining;
    busy         = 1'b0;
    done         = 1'b0;
    mem_we       = 1'b0;
    disk_tr      = 1'b0;
    disk_data    = '0;

    case (state)
      IDLE: begin
        if (start) begin
          disk_ptr_nx  = disk_base;
          mem_ptr_nx   = mem_base;
          remaining_nx = length;
          if (length == '0)
            state_nx = DONE;
          else if (dir)
            state_nx = M2D_RD;
          else
            state_nx = D2M;
        end
      end
      D2M: begin
        busy         = 1'b1;
        mem_we       = 1'b1;
        disk_ptr_nx  = disk_ptr + DISK_ADDR_WIDTH'(1);
        mem_ptr_nx   = mem_ptr + MEM_ADDR_WIDTH'(1);
        remaining_nx = remaining - LEN_WIDTH'(1);
        if (remaining == LEN_WIDTH'(1))
          state_nx = DONE;
      end
      M2D_RD: begin
        busy     = 1'b1;
        state_nx = M2D_WR;
      end
      M2D_WR: begin
        busy         = 1'b1;
        disk_tr      = 1'b1;
        disk_data    = mem_q;
        disk_ptr_nx  = disk_ptr + DISK_ADDR_WIDTH'(1);
        mem_ptr_nx   = mem_ptr + MEM_ADDR_WIDTH'(1);
        remaining_nx = remaining - LEN_WIDTH'(1);
        state_nx     = (remaining == LEN_WIDTH'(1)) ? DONE : M2D_RD;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign disk_addr = disk_ptr;
  assign mem_addr  = mem_ptr;
  assign mem_data  = disk_q;

endmodule
